// File: rtl/quad_rr_collector_pkg.sv
// Shared types and constants for the four-channel round-robin collector.
package quad_rr_collector_pkg;

   localparam int DATA_W_DEF = 8;

   localparam logic [1:0] CH_A = 2'd0;
   localparam logic [1:0] CH_B = 2'd1;
   localparam logic [1:0] CH_C = 2'd2;
   localparam logic [1:0] CH_D = 2'd3;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

   function automatic logic [1:0] rr_idx(logic [1:0] base, logic [1:0] off);
      return base + off;
   endfunction

endpackage

// File: rtl/quad_rr_collector_rr_arbiter4.sv
// Four-way round-robin arbiter: search begins one past the last grant.
module rr_arbiter4
   import quad_rr_collector_pkg::*;
(
   input  logic [3:0] req,
   input  logic [1:0] last_grant,
   output logic [3:0] grant,
   output logic [1:0] grant_idx,
   output logic       any
);

   logic [1:0] idx;

   // Walk from lowest to highest priority so the nearest requester wins.
   always_comb begin
      idx       = '0;
      grant_idx = '0;
      for (int k = 4; k >= 1; k--) begin
         idx = rr_idx(last_grant, 2'(k));
         if (req[idx]) begin
            grant_idx = idx;
         end
      end
   end

   assign any   = |req;
   assign grant = any ? (4'b0001 << grant_idx) : 4'b0000;

endmodule

// File: rtl/quad_rr_collector.sv
// Collects words from four producers into one registered output slot,
// granting channels round-robin and counting accepted words per channel.
module quad_rr_collector
   import quad_rr_collector_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
)
(
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] A,
   input  logic [DATA_W-1:0] B,
   input  logic [DATA_W-1:0] C,
   input  logic [DATA_W-1:0] D,
   input  logic [3:0]        in_valid,
   output logic [3:0]        in_ready,
   input  logic              enable_n,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        out_sel,
   output logic              out_valid,
   input  logic              out_ready,
   input  logic [1:0]        stat_sel,
   output logic [7:0]        stat_count
);

   state_t            state;
   state_t            state_nx;
   logic [1:0]        last_grant;
   logic [3:0]        grant;
   logic [1:0]        grant_idx;
   logic              any;
   logic              slot_free;
   logic              xfer;
   logic [DATA_W-1:0] mux_data;
   logic [7:0]        cnt [4];

   rr_arbiter4 u_arb (
      .req        (in_valid),
      .last_grant (last_grant),
      .grant      (grant),
      .grant_idx  (grant_idx),
      .any        (any)
   );

   assign out_valid = (state == FULL);
   assign slot_free = !out_valid || out_ready;
   // The grant is exactly the transfer; data never feeds back into it.
   assign xfer      = !rst && !enable_n && slot_free && any;
   assign in_ready  = xfer ? grant : 4'b0000;

   always_comb begin
      mux_data = A;
      unique case (grant_idx)
         CH_A: mux_data = A;
         CH_B: mux_data = B;
         CH_C: mux_data = C;
         CH_D: mux_data = D;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= EMPTY;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         EMPTY: if (xfer) state_nx = FULL;
         FULL:  if (out_ready && !xfer) state_nx = EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_data   <= '0;
         out_sel    <= CH_A;
         last_grant <= CH_D;
         for (int i = 0; i < 4; i++) begin
            cnt[i] <= 8'd0;
         end
      end else if (xfer) begin
         out_data        <= mux_data;
         out_sel         <= grant_idx;
         last_grant      <= grant_idx;
         cnt[grant_idx]  <= cnt[grant_idx] + 8'd1;
      end
   end

   assign stat_count = cnt[stat_sel];

endmodule

// File: tb/tb_quad_rr_collector.sv
// Directed bench for quad_rr_collector with a per-cycle reference model.
module tb_quad_rr_collector;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] da = 8'h00;
   logic [7:0] db = 8'h00;
   logic [7:0] dc = 8'h00;
   logic [7:0] dd = 8'h00;
   logic [3:0] in_valid = 4'b0000;
   logic [3:0] in_ready;
   logic       enable_n = 1'b0;
   logic [7:0] out_data;
   logic [1:0] out_sel;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [1:0] stat_sel = 2'b00;
   logic [7:0] stat_count;

   int checks = 0;
   int errors = 0;
   bit armed  = 1'b0;

   // Reference model state
   bit m_valid = 1'b0;
   int m_data  = 0;
   int m_sel   = 0;
   int m_last  = 3;
   int m_cnt [4] = '{0, 0, 0, 0};

   quad_rr_collector #(.DATA_W(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .A          (da),
      .B          (db),
      .C          (dc),
      .D          (dd),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .enable_n   (enable_n),
      .out_data   (out_data),
      .out_sel    (out_sel),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .stat_sel   (stat_sel),
      .stat_count (stat_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int ch_data(input int c);
      case (c)
         0: return int'(da);
         1: return int'(db);
         2: return int'(dc);
         default: return int'(dd);
      endcase
   endfunction

   // Which channel must be granted right now, or -1 for none.
   function automatic int exp_grant();
      if (rst || enable_n) return -1;
      if (m_valid && !out_ready) return -1;
      for (int j = 1; j <= 4; j++) begin
         if (in_valid[(m_last + j) % 4]) return (m_last + j) % 4;
      end
      return -1;
   endfunction

   always @(negedge clk) begin
      int g;
      int er;
      g  = exp_grant();
      er = (g < 0) ? 0 : (1 << g);
      if (armed) begin
         chk("in_ready", int'(in_ready), er);
         chk("out_valid", int'(out_valid), int'(m_valid));
         if (m_valid) begin
            chk("out_data", int'(out_data), m_data);
            chk("out_sel", int'(out_sel), m_sel);
         end
         chk("stat_count", int'(stat_count), m_cnt[stat_sel]);
      end
      if (rst) begin
         m_valid = 1'b0;
         m_data  = 0;
         m_sel   = 0;
         m_last  = 3;
         for (int i = 0; i < 4; i++) m_cnt[i] = 0;
      end else if (g >= 0) begin
         m_valid  = 1'b1;
         m_data   = ch_data(g);
         m_sel    = g;
         m_last   = g;
         m_cnt[g] = (m_cnt[g] + 1) % 256;
      end else if (m_valid && out_ready) begin
         m_valid = 1'b0;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [3:0] pat_v [8] = '{4'b1111, 4'b0101, 4'b1000, 4'b0000,
                             4'b0110, 4'b1011, 4'b0001, 4'b1110};
   bit pat_r [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
   bit pat_e [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

   initial begin
      // Reset state; in_ready held low while rst is high
      in_valid = 4'b1111;
      tick();
      tick();
      armed = 1'b1;
      chk("rst_in_ready", int'(in_ready), 0);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_out_data", int'(out_data), 0);
      chk("rst_out_sel", int'(out_sel), 0);
      chk("rst_count", int'(stat_count), 0);
      rst = 1'b0;
      in_valid = 4'b0000;

      // Full round-robin sweep at one word per cycle
      da = 8'h11; db = 8'h22; dc = 8'h33; dd = 8'h44;
      in_valid = 4'b1111;
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         chk("rr_seq", int'(out_sel), i % 4);
         chk("rr_valid", int'(out_valid), 1);
      end
      in_valid = 4'b0000;
      stat_sel = 2'd3;
      #1;
      chk("rr_count_d", int'(stat_count), 2);
      tick();

      // Stall holds the word and blocks grants
      da = 8'h3C;
      in_valid = 4'b0001;
      out_ready = 1'b0;
      tick();
      chk("stall_data", int'(out_data), 8'h3C);
      chk("stall_sel", int'(out_sel), 0);
      for (int i = 0; i < 3; i++) begin
         chk("stall_ready", int'(in_ready), 0);
         tick();
         chk("stall_hold", int'(out_data), 8'h3C);
      end
      in_valid = 4'b0000;
      out_ready = 1'b1;
      tick();
      chk("stall_drain", int'(out_valid), 0);

      // last_grant = B, then requests on B and D
      in_valid = 4'b0010;
      tick();
      in_valid = 4'b0000;
      tick();
      in_valid = 4'b1010;
      #1;
      chk("bd_first_ready", int'(in_ready), 4'b1000);
      tick();
      chk("bd_first_sel", int'(out_sel), 3);
      chk("bd_second_ready", int'(in_ready), 4'b0010);
      tick();
      chk("bd_second_sel", int'(out_sel), 1);
      chk("bd_third_ready", int'(in_ready), 4'b1000);
      in_valid = 4'b0000;
      tick();

      // Disable blocks grants; resume continues after last grant (B)
      enable_n = 1'b1;
      in_valid = 4'b1111;
      #1;
      chk("dis_ready", int'(in_ready), 0);
      tick();
      chk("dis_valid", int'(out_valid), 0);
      tick();
      enable_n = 1'b0;
      #1;
      chk("resume_ready", int'(in_ready), 4'b0100);
      tick();
      chk("resume_sel", int'(out_sel), 2);
      in_valid = 4'b0000;
      tick();

      // Disable does not discard a held word
      da = 8'h5A;
      in_valid = 4'b0001;
      out_ready = 1'b0;
      tick();
      enable_n = 1'b1;
      tick();
      chk("dis_hold_valid", int'(out_valid), 1);
      chk("dis_hold_data", int'(out_data), 8'h5A);
      out_ready = 1'b1;
      tick();
      chk("dis_drain", int'(out_valid), 0);
      enable_n = 1'b0;
      in_valid = 4'b0000;

      // Counter wrap on channel C
      rst = 1'b1;
      tick();
      rst = 1'b0;
      stat_sel = 2'd2;
      in_valid = 4'b0100;
      for (int i = 0; i < 255; i++) begin
         dc = 8'(i);
         tick();
      end
      chk("wrap_255", int'(stat_count), 255);
      tick();
      chk("wrap_0", int'(stat_count), 0);
      for (int s = 0; s < 4; s++) begin
         if (s != 2) begin
            stat_sel = 2'(s);
            #1;
            chk("wrap_other", int'(stat_count), 0);
         end
      end

      // Reset beats a same-cycle transfer and discards the held word
      in_valid = 4'b0001;
      tick();
      chk("pre_rst_sel", int'(out_sel), 0);
      out_ready = 1'b0;
      rst = 1'b1;
      #1;
      chk("rst_cycle_ready", int'(in_ready), 0);
      tick();
      chk("post_rst_valid", int'(out_valid), 0);
      stat_sel = 2'd0;
      #1;
      chk("post_rst_count", int'(stat_count), 0);
      rst = 1'b0;
      in_valid = 4'b1111;
      out_ready = 1'b1;
      #1;
      chk("post_rst_grant", int'(in_ready), 4'b0001);
      tick();
      chk("post_rst_sel", int'(out_sel), 0);

      // Mixed patterns, checked by the model each cycle
      for (int i = 0; i < 24; i++) begin
         da = 8'(8'hA0 + i);
         db = 8'(8'hB0 + i);
         dc = 8'(8'hC0 + i);
         dd = 8'(8'hD0 + i);
         in_valid = pat_v[i % 8];
         out_ready = pat_r[(i + i / 8) % 8];
         enable_n = pat_e[i % 8];
         stat_sel = 2'(i);
         tick();
      end
      in_valid = 4'b0000;
      enable_n = 1'b0;
      out_ready = 1'b1;
      tick();
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
